// File: rtl/pattern_pkg.sv
// pattern_pkg: definitions shared by the pattern RAM writer (pattern_loader)
// and the note sequencer that reads the same RAM.
//   state_e          - loader frame-parser states (CSUM exists only when
//                      PATTERN_LOADER_CHECKSUM_EN is defined)
//   SYNC_BYTE_DEFAULT - default frame start marker
//   NOTE/LEN/INSTR   - note word field positions; bit 15 is reserved (zero)
//   note_word()      - packs the three fields into a 16-bit note word
package pattern_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int unsigned NOTE_LSB  = 0;
  localparam int unsigned NOTE_W    = 6;
  localparam int unsigned LEN_LSB   = 6;
  localparam int unsigned LEN_W     = 5;
  localparam int unsigned INSTR_LSB = 11;
  localparam int unsigned INSTR_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_LO,
    ST_HI,
    ST_WRITE
`ifdef PATTERN_LOADER_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_e;

  function automatic logic [15:0] note_word(input logic [3:0] instr,
                                            input logic [4:0] len,
                                            input logic [5:0] note);
    logic [15:0] w;
    w = '0;
    w[NOTE_LSB  +: NOTE_W]  = note;
    w[LEN_LSB   +: LEN_W]   = len;
    w[INSTR_LSB +: INSTR_W] = instr;
    return w;
  endfunction

endpackage

// File: rtl/pattern_loader_if.sv
// pattern_loader_if: byte-stream input and pattern RAM write port of the
// pattern loader.
//   i_byte / i_byte_valid / o_byte_ready - host byte stream handshake
//   o_wr_en / o_wr_addr / o_wr_data       - single RAM write port
// Modports: slave = loader side, master = host/RAM side.
interface pattern_loader_if #(
  parameter int ADDR_WIDTH = 5
) ();

  logic [7:0]            i_byte;
  logic                  i_byte_valid;
  logic                  o_byte_ready;
  logic                  o_wr_en;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [15:0]           o_wr_data;

  modport slave (
    input  i_byte, i_byte_valid,
    output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data
  );

  modport master (
    output i_byte, i_byte_valid,
    input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data
  );

endinterface

// File: rtl/pattern_loader.sv
// pattern_loader: parses framed byte stream (SYNC, COUNT, N x {lo,hi}
// [, CSUM]) and writes 16-bit note words into the pattern RAM. On success
// publishes the new loop length and pulses o_done; aborted frames pulse
// o_error (words already written stay written).
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   bus (slave)   - byte stream handshake and RAM write port
//   o_loop_len    - last valid pattern index for the sequencer
//   o_busy        - frame in progress
//   o_done        - one-cycle pulse on successful frame
//   o_error       - one-cycle pulse on aborted frame
// Build option: PATTERN_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// (XOR of COUNT and every data byte) that must match for the frame to land.
module pattern_loader
  import pattern_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 5,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int unsigned DEFAULT_LEN = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pattern_loader_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] o_loop_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  state_e                state;
  logic                  ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [15:0]           wr_data_q;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [7:0]            lo;
`ifdef PATTERN_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif
  logic                  accept;

  assign accept           = bus.i_byte_valid & ready_q;
  assign bus.o_byte_ready = ready_q;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign o_busy           = (state != ST_IDLE);

  // Write address/data are loaded together with the HI byte so the strobe
  // in the WRITE cycle sees stable registered values; ready is pre-cleared
  // on entry to WRITE so it is low for exactly the stall cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      o_loop_len <= ADDR_WIDTH'(DEFAULT_LEN);
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      lo         <= '0;
`ifdef PATTERN_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      ready_q <= 1'b1;
      wr_en_q <= 1'b0;
      o_done  <= 1'b0;
      o_error <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept && bus.i_byte == SYNC_BYTE) state <= ST_COUNT;
        end
        ST_COUNT: begin
          if (accept) begin
            if ((bus.i_byte >> ADDR_WIDTH) != 8'd0) begin
              o_error <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              cnt   <= bus.i_byte[ADDR_WIDTH-1:0];
              idx   <= '0;
`ifdef PATTERN_LOADER_CHECKSUM_EN
              csum  <= bus.i_byte;
`endif
              state <= ST_LO;
            end
          end
        end
        ST_LO: begin
          if (accept) begin
            lo    <= bus.i_byte;
`ifdef PATTERN_LOADER_CHECKSUM_EN
            csum  <= csum ^ bus.i_byte;
`endif
            state <= ST_HI;
          end
        end
        ST_HI: begin
          if (accept) begin
            wr_data_q <= {bus.i_byte, lo};
            wr_addr_q <= idx;
            wr_en_q   <= 1'b1;
            ready_q   <= 1'b0;
`ifdef PATTERN_LOADER_CHECKSUM_EN
            csum      <= csum ^ bus.i_byte;
`endif
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (idx == cnt) begin
`ifdef PATTERN_LOADER_CHECKSUM_EN
            state      <= ST_CSUM;
`else
            o_loop_len <= cnt;
            o_done     <= 1'b1;
            state      <= ST_IDLE;
`endif
          end else begin
            idx   <= idx + ADDR_WIDTH'(1);
            state <= ST_LO;
          end
        end
`ifdef PATTERN_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) begin
            if (bus.i_byte == csum) begin
              o_loop_len <= cnt;
              o_done     <= 1'b1;
            end else begin
              o_error    <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// tb_pattern_loader: directed and randomized frames against a frame-level
// reference (expected RAM image, loop length and outcome per frame).
// Honours PATTERN_LOADER_CHECKSUM_EN in the same way as the design.
module tb_pattern_loader;
  import pattern_pkg::*;

  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pattern_loader_if #(.ADDR_WIDTH(AW)) bus ();
  logic [AW-1:0] loop_len;
  logic          busy, done, error;

  pattern_loader #(
    .ADDR_WIDTH (AW),
    .SYNC_BYTE  (8'hA5),
    .DEFAULT_LEN(15)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .o_loop_len(loop_len),
    .o_busy    (busy),
    .o_done    (done),
    .o_error   (error)
  );

  int total = 0;
  int bad   = 0;
  int wr_count = 0;
  int gap_max  = 0;
  logic [15:0]   obs_ram [32];
  logic [15:0]   ref_ram [32];
  logic [AW-1:0] ref_len;
  logic [15:0]   fw [$];

  // RAM image as seen on the write port
  always @(negedge clk) begin
    if (!rst && bus.o_wr_en === 1'b1) begin
      wr_count++;
      obs_ram[bus.o_wr_addr] = bus.o_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends at posedge+1; byte offered after a random idle gap.
  task automatic send(input logic [7:0] b);
    bit got;
    got = 1'b0;
    bus.i_byte_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) step();
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.o_byte_ready === 1'b1) begin
        step();
        got = 1'b1;
      end
    end
    bus.i_byte_valid = 1'b0;
    if (!got) chk("byte_accept_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic [7:0] count_byte, input bit corrupt);
    int n;
    int wc0;
    int mism;
    logic [7:0] csum;
    bit ok;
    wc0 = wr_count;
    send(SYNC_BYTE_DEFAULT);
    send(count_byte);
    if ((count_byte >> AW) != 8'd0) begin
      @(negedge clk);
      chk("count_err_pulse", error, 1);
      chk("count_err_no_done", done, 0);
      chk("count_err_len", loop_len, ref_len);
      @(negedge clk);
      chk("count_err_one_cycle", error, 0);
      chk("count_err_idle", busy, 0);
      step();
      chk("count_err_no_write", wr_count - wc0, 0);
    end else begin
      n = int'(count_byte[AW-1:0]) + 1;
      csum = count_byte;
      for (int i = 0; i < n; i++) begin
        send(fw[i][7:0]);
        send(fw[i][15:8]);
        csum ^= fw[i][7:0] ^ fw[i][15:8];
        @(negedge clk);
        chk("wr_en_after_hi", bus.o_wr_en, 1);
        chk("ready_low_on_write", bus.o_byte_ready, 0);
        chk("wr_addr", bus.o_wr_addr, i);
        chk("wr_data", bus.o_wr_data, fw[i]);
        ref_ram[i] = fw[i];
        if (i != n - 1) step();
      end
`ifdef PATTERN_LOADER_CHECKSUM_EN
      step();
      ok = !corrupt;
      send(ok ? csum : (csum ^ 8'h01));
      @(negedge clk);
`else
      ok = 1'b1;
      @(negedge clk);
`endif
      if (ok) ref_len = count_byte[AW-1:0];
      chk("done_pulse", done, ok);
      chk("error_pulse", error, !ok);
      chk("loop_len", loop_len, ref_len);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("error_one_cycle", error, 0);
      chk("idle_after_frame", busy, 0);
      step();
      mism = 0;
      for (int i = 0; i < n; i++) if (obs_ram[i] !== ref_ram[i]) mism++;
      chk("ram_content", mism, 0);
      chk("write_count", wr_count - wc0, n);
    end
  endtask

  initial begin
    int wc;
    logic [7:0] c;
    bus.i_byte       = 8'h00;
    bus.i_byte_valid = 1'b0;
    ref_len          = AW'(15);
    #1 rst = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.o_byte_ready, 0);
    chk("rst_wr_en", bus.o_wr_en, 0);
    chk("rst_wr_addr", bus.o_wr_addr, 0);
    chk("rst_wr_data", bus.o_wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_loop_len", loop_len, 15);
    step();
    rst = 1'b0;
    bus.i_byte = 8'h00;
    bus.i_byte_valid = 1'b1;
    step();
    @(negedge clk);
    chk("idle_ready", bus.o_byte_ready, 1);
    chk("idle_discard", busy, 0);
    step();
    bus.i_byte_valid = 1'b0;

    // leading junk, then the reference frame with a bad checksum, then good
    send(8'h00);
    fw = '{16'h1234, 16'hABCD};
    run_frame(8'h01, 1'b1);
    send(8'h00);
    run_frame(8'h01, 1'b0);

    // COUNT with an upper bit set, followed by a valid frame
    run_frame(8'h20, 1'b0);
    fw = '{16'h0F0F};
    run_frame(8'h00, 1'b0);

    // full-size frame: last address 31, containing sync values as data
    gap_max = 1;
    fw = {};
    for (int i = 0; i < 32; i++)
      fw.push_back((i % 7 == 3) ? 16'hA5A5 : 16'($urandom));
    run_frame(8'h1F, 1'b0);

    // reset after the third data byte
    gap_max = 0;
    send(SYNC_BYTE_DEFAULT);
    send(8'h01);
    send(8'h34);
    send(8'h12);
    @(negedge clk);
    chk("rst_frame_write0", bus.o_wr_en, 1);
    ref_ram[0] = 16'h1234;
    step();
    send(8'hCD);
    #2 rst = 1'b1;
    wc = wr_count;
    bus.i_byte = 8'hAB;
    bus.i_byte_valid = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bus.o_byte_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_loop_len", loop_len, 15);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_byte_valid = 1'b0;
    ref_len = AW'(15);
    repeat (4) step();
    chk("midrst_no_write", wr_count - wc, 0);
    chk("midrst_idle", busy, 0);
    chk("midrst_len_after", loop_len, 15);

    // sync byte values inside the payload are data
    fw = '{16'hA5A5, 16'h00A5, 16'hA500};
    run_frame(8'h02, 1'b0);

    // randomized frames
    gap_max = 2;
    for (int r = 0; r < 8; r++) begin
      fw = {};
      for (int i = 0; i < 32; i++)
        fw.push_back(($urandom_range(0, 1) == 0) ? 16'($urandom)
                     : note_word(4'($urandom_range(0, 15)),
                                 5'($urandom_range(0, 31)),
                                 6'($urandom_range(0, 63))));
      c = {3'd0, 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 5) == 0) c[7:5] = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 2) == 0) send(8'($urandom_range(0, 255)) & 8'h5A);
      run_frame(c, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_loader.md
# pattern_loader

Writer side of the pattern memory read by the note sequencer. Accepts a framed byte stream from a host link (UART receiver or similar) and writes 16-bit note words (note[5:0], length[10:6], instrument[14:11]) into the pattern RAM through a single write port. On a successful frame it publishes the new loop length for the sequencer and pulses done.

## Interface
- `ADDR_WIDTH`, 5: pattern RAM address width; one frame carries at most 2^ADDR_WIDTH words.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `DEFAULT_LEN`, 15: reset value of `o_loop_len`, i.e. last valid index.
- `i_clk` in 1: clock; the only clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_byte` in 8: stream byte.
- `i_byte_valid` in 1: `i_byte` is valid.
- `o_byte_ready` in/out: out, 1; a byte is accepted on a cycle with `i_byte_valid & o_byte_ready`.
- `o_wr_en` out 1: RAM write strobe.
- `o_wr_addr` out ADDR_WIDTH: RAM write address.
- `o_wr_data` out 16: RAM write data.
- `o_loop_len` out ADDR_WIDTH: last valid pattern index for the sequencer.
- `o_busy` out 1: a frame is in progress, i.e. state is not IDLE.
- `o_done` out 1: one-cycle pulse when a frame completes successfully.
- `o_error` out 1: one-cycle pulse when a frame is aborted.

## Operation
- Frame format: SYNC, COUNT, then N words sent low byte then high byte, then CSUM (CSUM only with checksum enabled).
- COUNT encodes N-1 in bits [ADDR_WIDTH-1:0]. Bits above ADDR_WIDTH must be zero.
- States and transitions:
  - IDLE: discards every byte except SYNC_BYTE. SYNC_BYTE moves to COUNT.
  - COUNT: bad upper bits raise `o_error` and return to IDLE. Otherwise latch `cnt = COUNT[ADDR_WIDTH-1:0]`, clear the word index and go to LO.
  - LO: latch the low byte, go to HI.
  - HI: latch the high byte, go to WRITE.
  - WRITE: assert `o_wr_en` with addr = index and data = {hi, lo}. Then:
    - if index == cnt, go to CSUM (or finish the frame, if checksum is compiled out);
    - otherwise index+1, go to LO.
- Success: `o_loop_len <= cnt`, pulse `o_done`, go to IDLE.
- Checksum: XOR of the COUNT byte and every data byte. On mismatch: pulse `o_error`, leave `o_loop_len` unchanged, go to IDLE. Words already written are not rolled back.
- SYNC_BYTE values inside the payload are data, not resynchronisation.
- The index is ADDR_WIDTH bits and never wraps, because cnt ≤ 2^ADDR_WIDTH-1.

## Timing
- Reset values: state IDLE, `o_byte_ready` 0 while `i_rst` is high, `o_wr_en`/`o_done`/`o_error`/`o_busy` 0, `o_wr_addr` 0, `o_wr_data` 0, `o_loop_len` DEFAULT_LEN.
- `o_byte_ready` is 1 in every state except WRITE. Each word costs one stall cycle.
- `o_wr_en` rises the cycle after the HI byte is accepted and lasts exactly one cycle. All write outputs are registered.
- `o_done`/`o_error` rise the cycle after the deciding byte is accepted.
- `o_loop_len` changes in the same cycle as `o_done`.
- `i_byte_valid` low holds the state indefinitely. There is no timeout.
- Reset mid-frame: immediate return to IDLE. No write is issued after reset asserts. `o_loop_len` returns to DEFAULT_LEN.
- Minimum frame of N words, checksum on: 2 + 2N + 1 accepted bytes plus N stall cycles.

## Configuration
- `PATTERN_LOADER_CHECKSUM_EN`
  - Defined: the CSUM state exists, a trailing checksum byte is required, and mismatches produce `o_error`.
  - Undefined: no CSUM state and no checksum register. The frame completes in the cycle after the last WRITE. `o_error` arises only from a bad COUNT byte.

## Structure
- Shared package `pattern_pkg` holds:
  - the state enum;
  - the default `SYNC_BYTE`;
  - note word field positions: NOTE [5:0], LEN [10:6], INSTR [14:11], bit 15 reserved. The sequencer decoding the same words must use these.
- No sub-module. The checksum is an 8-bit XOR register inside `pattern_loader`.

## Test plan
- After reset (no frame): `o_loop_len`=15, all strobes 0. With `i_byte_valid`=1, `o_byte_ready`=1.
- Stream 00 A5 01 34 12 CD AB then checksum 01^34^12^CD^AB=0x41 -> expected results:
  - writes (0,0x1234) then (1,0xABCD);
  - `o_done` pulse;
  - `o_loop_len`=1;
  - each `o_wr_en` follows the HI byte by one cycle, with ready low that cycle.
- Same frame with checksum 0x42 -> both writes occur, `o_error` pulses, `o_loop_len` stays 15.
- COUNT=0x20 (upper bit set, ADDR_WIDTH=5) -> `o_error` one cycle later, no writes. A following valid frame loads normally.
- COUNT=0x1F, full 32 words -> last write address 31, `o_loop_len`=31, no wrap to address 0.
- Assert `i_rst` after the 3rd data byte -> IDLE, no further `o_wr_en`, `o_loop_len`=15. Payload byte A5 in a later frame is written as data.
